mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MEM_DEPTH, default 256: number of 32-bit words in the attached data_memory; valid word indices are 0..MEM_DEPTH-1.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  1  request strobe from the CPU; sampled only in IDLE.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_size  input  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-007 req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-010 busy  output  1  high while a request is in progress (state != IDLE).
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  load result; 0 for stores and errors.
REQ-013 resp_err  output  1  qualifies resp_valid: request rejected, no memory write occurred.
REQ-014 mem_address  output  32  word index to data_memory, equal to req_addr[31:2].
REQ-015 mem_write_data  output  32  full word to write.
REQ-016 mem_write  output  1  write enable; data_memory commits on the next posedge.
REQ-017 mem_read_data  input  32  combinational read data from data_memory for mem_address.

Function
REQ-018 The FSM SHALL have states IDLE, RD, WR and RESP, encoded in a registered state variable.
REQ-019 The unit SHALL latch req_we, req_size, req_signed, req_addr and req_wdata on the IDLE cycle where req=1; inputs SHALL be ignored in all other states.
REQ-020 Error check at accept: the request SHALL be rejected if req_size=11, if halfword and req_addr[0]=1, if word and req_addr[1:0]!=00, or if req_addr[31:2] >= MEM_DEPTH.
REQ-021 Rejected request: IDLE->RESP, then resp_valid=1, resp_err=1, resp_rdata=0, and mem_write SHALL stay 0.
REQ-022 Load: IDLE->RD->RESP; in RD, mem_read_data SHALL be captured; in RESP, resp_valid=1 with the extracted data; resp_valid SHALL occur 2 cycles after the accept edge.
REQ-023 Word store: IDLE->WR->RESP; in WR, mem_write=1 and mem_write_data=latched wdata.
REQ-024 Sub-word store (read-modify-write): IDLE->RD->WR->RESP; RD SHALL capture the old word, and WR SHALL write the old word with only the addressed lane(s) replaced.
REQ-025 Byte lanes SHALL be little-endian: byte k=addr[1:0] occupies bits [8k+7:8k]; halfword addr[1]=h occupies bits [16h+15:16h].
REQ-026 Load extraction SHALL right-align the addressed lane(s) and fill the upper bits with the lane MSB if req_signed=1, else with 0; word loads SHALL ignore req_signed.
REQ-027 From RESP, the FSM SHALL always return to IDLE; a req held high in RESP SHALL NOT be accepted until the following IDLE cycle (minimum 1 idle cycle between requests).
REQ-028 mem_write SHALL be decoded from state (high only in WR) and SHALL be exactly one cycle per store.
REQ-029 In IDLE and RESP, mem_address and mem_write_data SHALL be 0.
REQ-030 In RD and WR, mem_address SHALL hold the latched word index stable.
REQ-031 busy SHALL be high in RD, WR and RESP, and low in IDLE.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE and busy=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_write=0, mem_address=0 and mem_write_data=0, regardless of clk.
REQ-033 Reset asserted during RD or WR SHALL abort the request with no memory write committed and no resp_valid pulse; after rst_n rises, the first posedge SHALL sample req in IDLE.

Verification
REQ-034 Word store then load: store addr 0x10, wdata 0xDEADBEEF -> mem_write=1 at index 4 for one cycle, resp_valid 2 cycles after accept; load 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0.
REQ-035 Byte store RMW: mem[4]=0x11223344, store byte 0xAA to addr 0x12 -> one RD cycle, then write 0x11AA3344; no other write pulses.
REQ-036 Sign extension: mem[4]=0x0000F080; byte load addr 0x10 signed -> 0xFFFFFF80; unsigned -> 0x00000080; halfword load addr 0x10 signed -> 0xFFFFF080.
REQ-037 Errors: word load addr 0x12, halfword store addr 0x11, size=11, and word addr 0x400 with MEM_DEPTH=256 -> each gives resp_valid=1 with resp_err=1 one cycle after accept, mem_write never 1.
REQ-038 Back-to-back: req held high continuously -> each request is accepted only in IDLE, with exactly one resp_valid pulse per accepted request.
REQ-039 Mid-op reset: assert rst_n=0 between edges while in WR -> mem_write drops low without waiting for clk, mem[index] unchanged, no resp_valid pulse.

Source files
------------

// File: rtl/mem_access_unit.sv
// CPU-side load/store unit for a single-port, combinational-read word memory.
// It handles byte and halfword accesses: loads are extracted with sign/zero fill, stores use read-modify-write.
module mem_access_unit #(
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_busy,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_write_data,
  output logic        o_mem_write,
  input  logic [31:0] i_mem_read_data
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_rdword;

  logic        w_accept;
  logic        w_req_err;
  logic [4:0]  w_shift;
  logic [31:0] w_lane;
  logic [31:0] w_mask;
  logic [31:0] w_merged;
  logic [31:0] w_load_data;

  assign w_accept = (r_state == StIdle) && i_req;

  always_comb begin
    w_req_err = 1'b0;
    unique case (i_req_size)
      2'b00:   w_req_err = 1'b0;
      2'b01:   w_req_err = i_req_addr[0];
      2'b10:   w_req_err = (i_req_addr[1:0] != 2'b00);
      default: w_req_err = 1'b1;
    endcase
    if ({2'b00, i_req_addr[31:2]} >= MEM_DEPTH) begin
      w_req_err = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_err    <= 1'b0;
      r_rdword <= 32'h0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_we     <= i_req_we;
        r_size   <= i_req_size;
        r_signed <= i_req_signed;
        r_addr   <= i_req_addr;
        r_wdata  <= i_req_wdata;
        r_err    <= w_req_err;
      end
      if (r_state == StRd) begin
        r_rdword <= i_mem_read_data;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_req) begin
          if (w_req_err) begin
            w_state_d = StResp;
          end else if (i_req_we && (i_req_size == 2'b10)) begin
            w_state_d = StWr;
          end else begin
            w_state_d = StRd;
          end
        end
      end
      StRd:    w_state_d = r_we ? StWr : StResp;
      StWr:    w_state_d = StResp;
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Little-endian lanes: halfwords are aligned, so the byte offset also serves as their shift.
  assign w_shift = {r_addr[1:0], 3'b000};
  assign w_lane  = r_rdword >> w_shift;

  always_comb begin
    w_mask      = 32'hFFFF_FFFF;
    w_load_data = r_rdword;
    unique case (r_size)
      2'b00: begin
        w_mask      = 32'h0000_00FF << w_shift;
        w_load_data = {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
      end
      2'b01: begin
        w_mask      = 32'h0000_FFFF << w_shift;
        w_load_data = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
      end
      default: begin
        w_mask      = 32'hFFFF_FFFF;
        w_load_data = r_rdword;
      end
    endcase
  end

  // Word stores skip the read, but their all-ones mask makes the stale old word irrelevant.
  assign w_merged = (r_rdword & ~w_mask) | ((r_wdata << w_shift) & w_mask);

  always_comb begin
    o_busy           = (r_state != StIdle);
    o_resp_valid     = 1'b0;
    o_resp_err       = 1'b0;
    o_resp_rdata     = 32'h0;
    o_mem_address    = 32'h0;
    o_mem_write_data = 32'h0;
    o_mem_write      = 1'b0;
    unique case (r_state)
      StRd: begin
        o_mem_address = {2'b00, r_addr[31:2]};
      end
      StWr: begin
        o_mem_address    = {2'b00, r_addr[31:2]};
        o_mem_write_data = w_merged;
        o_mem_write      = 1'b1;
      end
      StResp: begin
        o_resp_valid = 1'b1;
        o_resp_err   = r_err;
        o_resp_rdata = (r_err || r_we) ? 32'h0 : w_load_data;
      end
      default: begin
      end
    endcase
  end

endmodule
